// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared definitions for the two-requester bram arbiter.
//   req_id_t          - requester identity (REQ_A / REQ_B), also the round-robin state
//   tag_t             - read-return tag {valid, owner} carried alongside bram latency
//   BRAM_READ_LATENCY - clock edges from sampled read address to valid bram data_out
package bram_arbiter_pkg;

    localparam int unsigned BRAM_READ_LATENCY = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with its own last-grant register.
//   clk, rst     - clock, synchronous active-high reset
//   req_a, req_b - access requests
//   gnt_a, gnt_b - combinational grants; at most one high, only with its request
// After reset last grant is B, so A wins the first tie. The last-grant
// register holds through idle cycles.
module rr_arb2
    import bram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    req_id_t last_grant;

    always_comb begin
        gnt_a = req_a && (!req_b || (last_grant == REQ_B));
        gnt_b = req_b && !gnt_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_B;
        end else if (gnt_a) begin
            last_grant <= REQ_A;
        end else if (gnt_b) begin
            last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one simple dual-port bram between requesters A and B.
//   clk, rst                                  - clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata, a_gnt          - requester A access and combinational grant
//   a_rvalid/a_rdata                          - requester A read return
//   b_*                                       - same for requester B
//   mem_en/mem_we/mem_write_address/
//   mem_read_address/mem_data_in              - registered bram drive
//   mem_data_out                              - bram read data
// One access per cycle is issued through a register stage; a tag pipeline
// of READ_LATENCY+1 stages (issue register plus bram latency) routes each
// read return to its owner.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = BRAM_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    logic                  gnt_any;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    req_id_t               sel_owner;
    tag_t                  tag_pipe [READ_LATENCY+1];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (a_req),
        .req_b (b_req),
        .gnt_a (a_gnt),
        .gnt_b (b_gnt)
    );

    always_comb begin
        gnt_any   = a_gnt || b_gnt;
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        sel_owner = REQ_A;
        if (b_gnt) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_owner = REQ_B;
        end
    end

    // mem_en stays high out of reset: the bram read pipeline only advances
    // while enabled, so gating it would stall in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en            <= 1'b0;
            mem_we            <= 1'b0;
            mem_write_address <= '0;
            mem_read_address  <= '0;
            mem_data_in       <= '0;
            for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            mem_en <= 1'b1;
            mem_we <= 1'b0;
            if (gnt_any) begin
                if (sel_we) begin
                    mem_we            <= 1'b1;
                    mem_write_address <= sel_addr;
                    mem_data_in       <= sel_wdata;
                end else begin
                    mem_read_address  <= sel_addr;
                end
            end
            tag_pipe[0].valid <= gnt_any && !sel_we;
            tag_pipe[0].owner <= sel_owner;
            for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        a_rvalid = tag_pipe[READ_LATENCY].valid && (tag_pipe[READ_LATENCY].owner == REQ_A);
        b_rvalid = tag_pipe[READ_LATENCY].valid && (tag_pipe[READ_LATENCY].owner == REQ_B);
        a_rdata  = mem_data_out;
        b_rdata  = mem_data_out;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench for bram_arbiter with a behavioural
// two-edge-latency simple dual-port bram attached.
module tb_bram_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_write_address, mem_read_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_write_address(mem_write_address), .mem_read_address(mem_read_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Behavioural bram: read address sampled at one edge, data_out valid after the next.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic [DW-1:0] rd_stage;

    always @(posedge clk) begin
        if (rst) begin
            rd_stage     <= '0;
            mem_data_out <= '0;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_write_address] <= mem_data_in;
            rd_stage     <= mem_arr[mem_read_address];
            mem_data_out <= rd_stage;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mem_en"},   32'(mem_en), 32'h0);
        check({tag, "_mem_we"},   32'(mem_we), 32'h0);
        check({tag, "_waddr"},    32'(mem_write_address), 32'h0);
        check({tag, "_raddr"},    32'(mem_read_address), 32'h0);
        check({tag, "_wdata"},    mem_data_in, 32'h0);
        check({tag, "_a_rvalid"}, 32'(a_rvalid), 32'h0);
        check({tag, "_b_rvalid"}, 32'(b_rvalid), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;
    endtask

    initial begin
        mem_arr[10'h010] = 32'h11;
        mem_arr[10'h020] = 32'h22;
        mem_arr[10'h001] = 32'hA1;
        mem_arr[10'h002] = 32'hA2;
        mem_arr[10'h003] = 32'hA3;
        mem_arr[10'h000] = 32'h0;
        idle_inputs();
        do_reset();

        // Test 1: A writes, then reads back with 3-cycle return.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 32'hDEADBEEF;
        #1;
        check("t1_wr_a_gnt", 32'(a_gnt), 32'h1);
        check("t1_wr_b_gnt", 32'(b_gnt), 32'h0);
        check("t1_mem_en",   32'(mem_en), 32'h1);
        @(negedge clk);
        a_we = 1'b0;
        #1;
        check("t1_mem_we",    32'(mem_we), 32'h1);
        check("t1_waddr",     32'(mem_write_address), 32'h005);
        check("t1_wdata",     mem_data_in, 32'hDEADBEEF);
        check("t1_rd_a_gnt",  32'(a_gnt), 32'h1);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("t1_rd_mem_we", 32'(mem_we), 32'h0);
        check("t1_raddr",     32'(mem_read_address), 32'h005);
        check("t1_rv_r1",     32'(a_rvalid), 32'h0);
        @(negedge clk); #1;
        check("t1_rv_r2",     32'(a_rvalid), 32'h0);
        @(negedge clk); #1;
        check("t1_rv_r3",     32'(a_rvalid), 32'h1);
        check("t1_rdata",     a_rdata, 32'hDEADBEEF);
        check("t1_b_rv_r3",   32'(b_rvalid), 32'h0);
        @(negedge clk); #1;
        check("t1_rv_r4",     32'(a_rvalid), 32'h0);

        // Test 2: both read continuously from fresh reset -> A,B,A,B and gapless returns.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 6) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
                b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020;
            end else begin
                idle_inputs();
            end
            #1;
            if (i < 6) begin
                check("t2_a_gnt", 32'(a_gnt), 32'(i % 2 == 0));
                check("t2_b_gnt", 32'(b_gnt), 32'(i % 2 == 1));
            end
            if (i >= 3 && i < 9) begin
                check("t2_a_rvalid", 32'(a_rvalid), 32'((i - 3) % 2 == 0));
                check("t2_b_rvalid", 32'(b_rvalid), 32'((i - 3) % 2 == 1));
                check("t2_rdata", a_rdata, ((i - 3) % 2 == 0) ? 32'h11 : 32'h22);
            end else begin
                check("t2_a_rv_idle", 32'(a_rvalid), 32'h0);
                check("t2_b_rv_idle", 32'(b_rvalid), 32'h0);
            end
        end

        // Test 3: B writes top address, A reads it the next cycle.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 10'h3FF; b_wdata = 32'h12345678;
        #1;
        check("t3_b_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        idle_inputs();
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h3FF;
        #1;
        check("t3_a_gnt",  32'(a_gnt), 32'h1);
        check("t3_mem_we", 32'(mem_we), 32'h1);
        check("t3_waddr",  32'(mem_write_address), 32'h3FF);
        @(negedge clk);
        idle_inputs();
        #1;
        check("t3_raddr",  32'(mem_read_address), 32'h3FF);
        @(negedge clk); #1;
        check("t3_rv_n3",  32'(a_rvalid), 32'h0);
        @(negedge clk); #1;
        check("t3_rv_n4",  32'(a_rvalid), 32'h1);
        check("t3_rdata",  a_rdata, 32'h12345678);
        check("t3_b_rv",   32'(b_rvalid), 32'h0);

        // Test 4: three back-to-back A reads.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 3) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 10'(i + 1);
            end else begin
                idle_inputs();
            end
            #1;
            if (i < 3) check("t4_a_gnt", 32'(a_gnt), 32'h1);
            if (i >= 3 && i < 6) begin
                check("t4_rvalid", 32'(a_rvalid), 32'h1);
                check("t4_rdata",  a_rdata, 32'(32'hA0 + i - 2));
            end else begin
                check("t4_rv_idle", 32'(a_rvalid), 32'h0);
            end
        end

        // Test 5: B read aborted by a one-cycle reset right after its grant.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020;
        #1;
        check("t5_b_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("t5");
        for (int k = 3; k < 7; k++) begin
            @(negedge clk); #1;
            check("t5_b_rv_none", 32'(b_rvalid), 32'h0);
            check("t5_a_rv_none", 32'(a_rvalid), 32'h0);
        end
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h000;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h000;
        #1;
        check("t5_tie_a_gnt", 32'(a_gnt), 32'h1);
        check("t5_tie_b_gnt", 32'(b_gnt), 32'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk); #1;
        check("t5_tie_a_rv", 32'(a_rvalid), 32'h1);
        check("t5_tie_b_rv", 32'(b_rvalid), 32'h0);
        @(negedge clk); #1;
        check("t5_drain_a_rv", 32'(a_rvalid), 32'h0);

        // Test 6: 20 cycles of sparse A writes, no reads.
        begin
            logic prev_gnt;
            prev_gnt = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                a_req = (i % 3 == 0); a_we = 1'b1; a_addr = 10'(i); a_wdata = 32'(i);
                #1;
                check("t6_a_gnt",    32'(a_gnt), 32'(i % 3 == 0));
                check("t6_mem_we",   32'(mem_we), 32'(prev_gnt));
                check("t6_a_rvalid", 32'(a_rvalid), 32'h0);
                check("t6_b_rvalid", 32'(b_rvalid), 32'h0);
                prev_gnt = (i % 3 == 0);
            end
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
